// File: rtl/bcd_time_counter_pkg.sv
// Shared constants and helpers for the BCD time-of-day counter.
// Digit limits are BCD-encoded so they compare directly against counter registers.
package bcd_time_counter_pkg;

  localparam logic [7:0] SEC_MAX     = 8'h59;
  localparam logic [7:0] MIN_MAX     = 8'h59;
  localparam logic [7:0] HR_MAX      = 8'h23;
  localparam logic [7:0] NOON_BCD    = 8'h12;
  localparam int         HR12_OFFSET = 12;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] min;
    logic [7:0] sec;
  } bcd_time_t;

  // 24-hour BCD hour to 12-hour BCD hour: 00 -> 12, 13..23 -> 01..11.
  function automatic logic [7:0] hr_to_12(input logic [7:0] hr);
    logic [4:0] bin;
    logic [4:0] h12;
    bin = 5'(hr[7:4]) * 5'd10 + 5'(hr[3:0]);
    if (bin == 5'd0)
      h12 = 5'(HR12_OFFSET);
    else if (bin > 5'(HR12_OFFSET))
      h12 = bin - 5'(HR12_OFFSET);
    else
      h12 = bin;
    if (h12 >= 5'd10)
      hr_to_12 = {4'd1, 4'(h12 - 5'd10)};
    else
      hr_to_12 = {4'd0, h12[3:0]};
  endfunction

endpackage

// File: rtl/bcd_time_counter_mod.sv
// Two-digit BCD modulo counter (00..MAX_VAL). carry_out is combinational so a
// chain of these counters ripples seconds -> minutes -> hours on one edge.
module bcd_mod_counter #(
  parameter logic [7:0] MAX_VAL = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clear,
  output logic [7:0] value,
  output logic       carry_out
);

  logic at_max;

  assign at_max    = (value == MAX_VAL);
  // clear wins over inc, so a cleared counter never carries.
  assign carry_out = inc && !clear && at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 8'h00;
    end else if (clear) begin
      value <= 8'h00;
    end else if (inc) begin
      if (at_max)
        value <= 8'h00;
      else if (value[3:0] == 4'd9)
        value <= {value[7:4] + 4'd1, 4'd0};
      else
        value <= {value[7:4], value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour BCD time-of-day counter with a one-second prescaler, manual set mode
// and a 12-hour display view. All inputs are single-cycle pulses, no handshake.
module bcd_time_counter
  import bcd_time_counter_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_mode,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       clr_sec,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] hr12_bcd,
  output logic       pm,
  output logic       day_rollover
);

  localparam int             PW   = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic          sec_tick;
  logic          sec_carry;
  logic          min_carry;
  logic          hr_carry;
  logic          min_inc;
  logic          hr_inc;
  bcd_time_t     now;

  assign sec_tick = !set_mode && (presc == TERM);

  // Set mode freezes the prescaler at 0 so a full second follows its release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      presc <= '0;
    else if (set_mode || clr_sec || sec_tick)
      presc <= '0;
    else
      presc <= presc + PW'(1);
  end

  // In set mode the buttons drive minutes/hours directly and the carry chain is cut.
  assign min_inc = set_mode ? inc_min : sec_carry;
  assign hr_inc  = set_mode ? inc_hr  : min_carry;

  bcd_mod_counter #(.MAX_VAL(SEC_MAX)) u_sec (
    .clk(clk), .rst(reset), .inc(sec_tick), .clear(clr_sec),
    .value(now.sec), .carry_out(sec_carry)
  );

  bcd_mod_counter #(.MAX_VAL(MIN_MAX)) u_min (
    .clk(clk), .rst(reset), .inc(min_inc), .clear(1'b0),
    .value(now.min), .carry_out(min_carry)
  );

  bcd_mod_counter #(.MAX_VAL(HR_MAX)) u_hr (
    .clk(clk), .rst(reset), .inc(hr_inc), .clear(1'b0),
    .value(now.hr), .carry_out(hr_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      day_rollover <= 1'b0;
    else
      day_rollover <= hr_carry && !set_mode;
  end

  assign hr_bcd   = now.hr;
  assign min_bcd  = now.min;
  assign sec_bcd  = now.sec;
  assign hr12_bcd = hr_to_12(now.hr);
  assign pm       = (now.hr >= NOON_BCD);

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: a seconds-of-day reference model feeds an expected
// queue per clock edge; a monitor pops and compares after every rising edge.
module tb_bcd_time_counter;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       set_mode;
  logic       inc_hr;
  logic       inc_min;
  logic       clr_sec;
  logic [7:0] hr_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [7:0] hr12_bcd;
  logic       pm;
  logic       day_rollover;

  int checks   = 0;
  int failures = 0;
  int roll_seen = 0;

  logic [33:0] exp_q[$];

  int m_h, m_m, m_s, m_presc;
  bit m_roll;

  bcd_time_counter #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset(reset), .set_mode(set_mode), .inc_hr(inc_hr),
    .inc_min(inc_min), .clr_sec(clr_sec), .hr_bcd(hr_bcd), .min_bcd(min_bcd),
    .sec_bcd(sec_bcd), .hr12_bcd(hr12_bcd), .pm(pm), .day_rollover(day_rollover)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [33:0] expect_vec();
    int h12;
    h12 = (m_h % 12 == 0) ? 12 : m_h % 12;
    return {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), to_bcd(h12), logic'(m_h >= 12), logic'(m_roll)};
  endfunction

  function automatic void model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_presc = 0; m_roll = 0;
  endfunction

  // Reference behaviour of one rising edge, on plain integers.
  function automatic void model_edge(input bit sm, input bit ih, input bit im, input bit cs);
    int  t;
    bit  tick;
    m_roll = 0;
    if (sm) begin
      m_presc = 0;
      if (im) m_m = (m_m + 1) % 60;
      if (ih) m_h = (m_h + 1) % 24;
      if (cs) m_s = 0;
    end else begin
      tick    = (m_presc == T - 1);
      m_presc = tick ? 0 : m_presc + 1;
      if (cs) begin
        m_s = 0;
        m_presc = 0;
      end else if (tick) begin
        t = m_h * 3600 + m_m * 60 + m_s + 1;
        if (t == 86400) begin
          t = 0;
          m_roll = 1;
        end
        m_h = t / 3600;
        m_m = (t / 60) % 60;
        m_s = t % 60;
      end
    end
  endfunction

  task automatic check_vec(input string name, input logic [33:0] e);
    logic [33:0] act;
    act = {hr_bcd, min_bcd, sec_bcd, hr12_bcd, pm, day_rollover};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s @%0t: got hr=%h min=%h sec=%h hr12=%h pm=%b roll=%b, expected hr=%h min=%h sec=%h hr12=%h pm=%b roll=%b",
               name, $time, act[33:26], act[25:18], act[17:10], act[9:2], act[1], act[0],
               e[33:26], e[25:18], e[17:10], e[9:2], e[1], e[0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int e);
    checks++;
    if (act != e) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, e);
    end
  endtask

  // driver: drive inputs for the coming edge, log expectation, wait to next negedge
  task automatic step(input bit sm, input bit ih, input bit im, input bit cs);
    set_mode = sm; inc_hr = ih; inc_min = im; clr_sec = cs;
    model_edge(sm, ih, im, cs);
    exp_q.push_back(expect_vec());
    @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m);
    int g;
    g = 0;
    while (m_m != m && g < 100) begin step(1, 0, 1, 0); g++; end
    while (m_h != h && g < 200) begin step(1, 1, 0, 0); g++; end
    check_val("set_time_reached", (m_h == h && m_m == m) ? 1 : 0, 1);
  endtask

  task automatic run_until(input int s, input int p);
    int g;
    g = 0;
    while (!(m_s == s && m_presc == p) && g < 400) begin step(0, 0, 0, 0); g++; end
    check_val("run_until_reached", (m_s == s && m_presc == p) ? 1 : 0, 1);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [33:0] e;
    #1;
    if (day_rollover) roll_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_vec("cycle", e);
    end
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int sm_r;
    int saved_m;
    reset = 1'b1; set_mode = 1'b0; inc_hr = 1'b0; inc_min = 1'b0; clr_sec = 1'b0;
    model_reset();
    @(negedge clk);
    check_vec("reset_state", expect_vec());
    reset = 1'b0;

    // one minute of free running; run-mode button pulses must be ignored
    repeat (240) step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0);
    check_val("min_after_240", min_bcd, 8'h01);
    check_val("sec_after_240", sec_bcd, 8'h00);
    check_val("hr_after_240", hr_bcd, 8'h00);

    // 23:59:00 -> midnight rollover
    step(1, 0, 0, 1);
    set_time(23, 59);
    roll_seen = 0;
    repeat (240) step(0, 0, 0, 0);
    check_val("midnight_hr", hr_bcd, 8'h00);
    check_val("midnight_min", min_bcd, 8'h00);
    check_val("midnight_sec", sec_bcd, 8'h00);
    check_val("midnight_hr12", hr12_bcd, 8'h12);
    check_val("midnight_pm", pm, 0);
    check_val("midnight_roll_now", day_rollover, 1);
    repeat (4) step(0, 0, 0, 0);
    check_val("rollover_pulses", roll_seen, 1);

    // 24 inc_hr pulses in set mode return to 00 without rollover
    roll_seen = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      step(1, 1, 0, 0);
      if (m_h == 13) begin
        check_val("hr13_hr12", hr12_bcd, 8'h01);
        check_val("hr13_pm", pm, 1);
      end
      step(1, 0, 0, 0);
    end
    check_val("hr_wrap_24", hr_bcd, 8'h00);
    check_val("hr_wrap_no_roll", roll_seen, 0);

    // simultaneous inc_hr and inc_min at 09:59
    set_time(9, 59);
    step(1, 1, 1, 0);
    check_val("both_inc_hr", hr_bcd, 8'h10);
    check_val("both_inc_min", min_bcd, 8'h00);

    // clr_sec coincident with the tick at sec 59
    run_until(59, T - 1);
    saved_m = m_m;
    step(0, 0, 0, 1);
    check_val("clr_at_59_sec", sec_bcd, 8'h00);
    check_val("clr_at_59_min", min_bcd, to_bcd(saved_m));
    step(0, 0, 1, 0);
    check_val("run_inc_min_ignored", min_bcd, to_bcd(saved_m));

    // randomized mix of modes and pulses
    sm_r = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) sm_r = 1 - sm_r;
      step(sm_r[0], $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 19) == 0);
    end

    // asynchronous reset at 12:34:56 mid-second
    step(1, 0, 0, 1);
    set_time(12, 34);
    run_until(56, 2);
    set_mode = 1'b0; inc_hr = 1'b0; inc_min = 1'b0; clr_sec = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_vec("async_reset", expect_vec());
    check_val("async_reset_hr12", hr12_bcd, 8'h12);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) step(0, 0, 0, 0);
    check_val("post_reset_sec", sec_bcd, 8'h03);

    @(posedge clk);
    #2;
    check_val("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
